hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with load-use stall FSM, operand forwarding and stall/flush counters.
module hazard_ctrl #(
    parameter logic [2:0] WD_DRAM  = 3'd1,
    parameter int         LU_STALL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_re1,
    input  logic        ID_re2,
    input  logic [4:0]  EX_wR,
    input  logic        EX_we_rf,
    input  logic [2:0]  EX_wd_sel,
    input  logic [4:0]  MEM_wR,
    input  logic        MEM_we_rf,
    input  logic [4:0]  WB_wR,
    input  logic        WB_we_rf,
    input  logic        EX_redirect,
    input  logic        mem_busy,
    input  logic        clr_cnt,
    output logic        stall_PC,
    output logic        stall_IF_ID,
    output logic        stall_ID_EX,
    output logic        stall_EX_MEM,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic [1:0]  fwd_A_sel,
    output logic [1:0]  fwd_B_sel,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);
    typedef enum logic {RUN = 1'b0, LU_WAIT = 1'b1} state_t;
    localparam logic [1:0] LU_INIT = 2'(LU_STALL - 1);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_lu_cnt, w_lu_cnt_nxt;
    logic [15:0] r_stall_cycles, r_flush_events;
    logic        w_lu_hazard, w_busy, w_redir, w_lu;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        return (MEM_we_rf && MEM_wR != 5'd0 && MEM_wR == rs) ? 2'b01 :
               (WB_we_rf  && WB_wR  != 5'd0 && WB_wR  == rs) ? 2'b10 : 2'b00;
    endfunction

    assign w_lu_hazard = EX_we_rf && EX_wd_sel == WD_DRAM && EX_wR != 5'd0 &&
                         ((ID_re1 && ID_rs1 == EX_wR) || (ID_re2 && ID_rs2 == EX_wR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_lu_cnt <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    // mem_busy freezes the FSM; redirect aborts any pending load-use wait
    always_comb begin
        w_state_nxt  = r_state;
        w_lu_cnt_nxt = r_lu_cnt;
        if (!mem_busy) begin
            if (EX_redirect) begin
                w_state_nxt  = RUN;
                w_lu_cnt_nxt = 2'd0;
            end else if (r_state == LU_WAIT) begin
                w_lu_cnt_nxt = r_lu_cnt - 2'd1;
                w_state_nxt  = (r_lu_cnt == 2'd1) ? RUN : LU_WAIT;
            end else if (w_lu_hazard && LU_STALL > 1) begin
                w_state_nxt  = LU_WAIT;
                w_lu_cnt_nxt = LU_INIT;
            end
        end
    end

    always_comb begin
        w_busy       = rst_n && mem_busy;
        w_redir      = rst_n && !mem_busy && EX_redirect;
        w_lu         = rst_n && !mem_busy && !EX_redirect && (r_state == LU_WAIT || w_lu_hazard);
        stall_PC     = w_busy || w_lu;
        stall_IF_ID  = w_busy || w_lu;
        stall_ID_EX  = w_busy;
        stall_EX_MEM = w_busy;
        flush_IF_ID  = w_redir;
        flush_ID_EX  = w_redir || w_lu;
        fwd_A_sel    = rst_n ? fwd_sel(ID_rs1) : 2'b00;
        fwd_B_sel    = rst_n ? fwd_sel(ID_rs2) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            r_stall_cycles <= 16'd0;
            r_flush_events <= 16'd0;
        end else begin
            if (stall_PC && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_redir && r_flush_events != 16'hFFFF)
                r_flush_events <= r_flush_events + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench driving LU_STALL=1 and LU_STALL=3 instances against a cycle model.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ID_rs1, ID_rs2, EX_wR, MEM_wR, WB_wR;
    logic       ID_re1, ID_re2, EX_we_rf, MEM_we_rf, WB_we_rf;
    logic [2:0] EX_wd_sel;
    logic       EX_redirect, mem_busy, clr_cnt;
    logic [5:0] ctl1, ctl3;
    logic [3:0] fwd1, fwd3;
    logic [15:0] sc1, fe1, sc3, fe3;
    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;
    int rem [2];
    int sc [2];
    int fe [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.WD_DRAM(3'd1), .LU_STALL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_re1(ID_re1), .ID_re2(ID_re2),
        .EX_wR(EX_wR), .EX_we_rf(EX_we_rf), .EX_wd_sel(EX_wd_sel), .MEM_wR(MEM_wR), .MEM_we_rf(MEM_we_rf),
        .WB_wR(WB_wR), .WB_we_rf(WB_we_rf), .EX_redirect(EX_redirect), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .stall_PC(ctl1[5]), .stall_IF_ID(ctl1[4]), .stall_ID_EX(ctl1[3]), .stall_EX_MEM(ctl1[2]),
        .flush_IF_ID(ctl1[1]), .flush_ID_EX(ctl1[0]), .fwd_A_sel(fwd1[3:2]), .fwd_B_sel(fwd1[1:0]),
        .stall_cycles(sc1), .flush_events(fe1));

    hazard_ctrl #(.WD_DRAM(3'd1), .LU_STALL(3)) u3 (
        .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_re1(ID_re1), .ID_re2(ID_re2),
        .EX_wR(EX_wR), .EX_we_rf(EX_we_rf), .EX_wd_sel(EX_wd_sel), .MEM_wR(MEM_wR), .MEM_we_rf(MEM_we_rf),
        .WB_wR(WB_wR), .WB_we_rf(WB_we_rf), .EX_redirect(EX_redirect), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .stall_PC(ctl3[5]), .stall_IF_ID(ctl3[4]), .stall_ID_EX(ctl3[3]), .stall_EX_MEM(ctl3[2]),
        .flush_IF_ID(ctl3[1]), .flush_ID_EX(ctl3[0]), .fwd_A_sel(fwd3[3:2]), .fwd_B_sel(fwd3[1:0]),
        .stall_cycles(sc3), .flush_events(fe3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (MEM_we_rf && MEM_wR != 0 && MEM_wR == rs) return 2'b01;
        if (WB_we_rf && WB_wR != 0 && WB_wR == rs) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0;
            sc[k] = 0;
            fe[k] = 0;
        end
    end

    // rem counts stall cycles still owed after the current one
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic haz;
                logic [5:0] e;
                int ls;
                ls = (k == 0) ? 1 : 3;
                haz = EX_we_rf && EX_wd_sel == 3'd1 && EX_wR != 0 &&
                      ((ID_re1 && ID_rs1 == EX_wR) || (ID_re2 && ID_rs2 == EX_wR));
                if (!rst_n) e = 6'b000000;
                else if (mem_busy) e = 6'b111100;
                else if (EX_redirect) e = 6'b000011;
                else if (rem[k] > 0 || haz) e = 6'b110001;
                else e = 6'b000000;
                check(k == 0 ? "m_ctl1" : "m_ctl3", k == 0 ? 32'(ctl1) : 32'(ctl3), 32'(e));
                check(k == 0 ? "m_fwd1" : "m_fwd3", k == 0 ? 32'(fwd1) : 32'(fwd3),
                      rst_n ? 32'({fsel(ID_rs1), fsel(ID_rs2)}) : 32'd0);
                check(k == 0 ? "m_cnt1" : "m_cnt3", k == 0 ? {sc1, fe1} : {sc3, fe3},
                      {sc[k][15:0], fe[k][15:0]});
                if (!rst_n) begin
                    rem[k] = 0;
                    sc[k] = 0;
                    fe[k] = 0;
                end else begin
                    if (clr_cnt) begin
                        sc[k] = 0;
                        fe[k] = 0;
                    end else begin
                        if (e[5] && sc[k] < 65535) sc[k]++;
                        if (EX_redirect && !mem_busy && fe[k] < 65535) fe[k]++;
                    end
                    if (mem_busy) rem[k] = rem[k];
                    else if (EX_redirect) rem[k] = 0;
                    else if (rem[k] > 0) rem[k]--;
                    else if (haz) rem[k] = ls - 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ID_rs1 = 0; ID_rs2 = 0; ID_re1 = 0; ID_re2 = 0;
        EX_wR = 0; EX_we_rf = 0; EX_wd_sel = 0;
        MEM_wR = 0; MEM_we_rf = 0; WB_wR = 0; WB_we_rf = 0;
        EX_redirect = 0; mem_busy = 0; clr_cnt = 0;
    endtask

    task automatic load;
        EX_we_rf = 1; EX_wd_sel = 3'd1; EX_wR = 5; ID_rs1 = 5; ID_re1 = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        load();
        MEM_we_rf = 1; MEM_wR = 5;
        mem_busy = 1;
        tick();
        chk_en = 1;
        #3;
        check("rst_ctl3", 32'(ctl3), 0);
        check("rst_fwd3", 32'(fwd3), 0);
        check("rst_sc3", 32'(sc3), 0);
        tick();
        rst_n = 1;
        idle();
        tick();
        load();
        #3;
        check("A1_ctl1", 32'(ctl1), 32'b110001);
        check("A1_ctl3", 32'(ctl3), 32'b110001);
        tick();
        idle();
        #3;
        check("A2_ctl1", 32'(ctl1), 0);
        check("A2_ctl3", 32'(ctl3), 32'b110001);
        tick();
        #3;
        check("A3_ctl3", 32'(ctl3), 32'b110001);
        tick();
        #3;
        check("A4_ctl3", 32'(ctl3), 0);
        check("A_sc1", 32'(sc1), 1);
        check("A_sc3", 32'(sc3), 3);
        tick();
        load();
        tick();
        idle();
        EX_redirect = 1;
        #3;
        check("B_ctl3", 32'(ctl3), 32'b000011);
        tick();
        idle();
        #3;
        check("B_after3", 32'(ctl3), 0);
        check("B_fe1", 32'(fe1), 1);
        check("B_fe3", 32'(fe3), 1);
        tick();
        load();
        tick();
        idle();
        mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check("C_busy3", 32'(ctl3), 32'b111100);
            tick();
        end
        idle();
        #3;
        check("C_res1", 32'(ctl3), 32'b110001);
        tick();
        #3;
        check("C_res2", 32'(ctl3), 32'b110001);
        tick();
        #3;
        check("C_end", 32'(ctl3), 0);
        load();
        EX_redirect = 1;
        #3;
        check("P_redir", 32'(ctl3), 32'b000011);
        tick();
        idle();
        EX_redirect = 1;
        mem_busy = 1;
        #3;
        check("P_busy", 32'(ctl3), 32'b111100);
        tick();
        idle();
        load();
        tick();
        idle();
        rst_n = 0;
        #3;
        check("R_ctl3", 32'(ctl3), 0);
        tick();
        rst_n = 1;
        #3;
        check("R_after3", 32'(ctl3), 0);
        tick();
        MEM_we_rf = 1; MEM_wR = 7; WB_we_rf = 1; WB_wR = 7; ID_rs1 = 0; ID_rs2 = 7;
        #3;
        check("D_fwd1", 32'(fwd3), 32'b0001);
        tick();
        MEM_wR = 0; WB_wR = 9; ID_rs1 = 0; ID_rs2 = 9;
        #3;
        check("D_fwd2", 32'(fwd3), 32'b0010);
        tick();
        WB_wR = 0; ID_rs1 = 0; ID_rs2 = 3;
        #3;
        check("D_fwd3", 32'(fwd3), 0);
        tick();
        idle();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        mem_busy = 1;
        repeat (70000) tick();
        #3;
        check("E_sat1", 32'(sc1), 32'hFFFF);
        check("E_sat3", 32'(sc3), 32'hFFFF);
        clr_cnt = 1;
        tick();
        #3;
        check("E_clr1", 32'(sc1), 0);
        check("E_clr3", 32'(sc3), 0);
        idle();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
